// File: rtl/dog_sub.sv
// Difference-of-Gaussian stage: aligns the leading small-sigma stream A against
// stream B through a FIFO and emits the signed difference B - A with raster coordinates.
module dog_sub #(
  parameter int WIDE   = 230,
  parameter int HIGN   = 235,
  parameter int DW     = 16,
  parameter int CNT_DW = 16,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_a,
  input  logic [DW-1:0]     data_a,
  input  logic              valid_b,
  input  logic [DW-1:0]     data_b,
  output logic              valid_dog,
  output logic [DW:0]       data_dog,
  output logic [CNT_DW-1:0] x_dog,
  output logic [CNT_DW-1:0] y_dog,
  output logic              frame_end,
  output logic [AW:0]       fifo_cnt,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_DW-1:0] X_LAST   = CNT_DW'(WIDE - 1);
  localparam logic [CNT_DW-1:0] Y_LAST   = CNT_DW'(HIGN - 1);

  logic [DW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       cnt_r;
  logic [CNT_DW-1:0] x_r;
  logic [CNT_DW-1:0] y_r;

  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              bypass_s;
  logic              pair_s;
  logic              udf_s;
  logic              ovf_s;
  logic [DW-1:0]     a_op_s;
  logic [DW:0]       diff_s;
  logic [CNT_DW-1:0] x_nxt_s;
  logic [CNT_DW-1:0] y_nxt_s;
  logic              last_s;

  // Pairing decisions, A operand selection, difference and next raster position.
  always_comb begin
    empty_s  = (cnt_r == {(AW+1){1'b0}});
    full_s   = (cnt_r == FULL_CNT);
    pop_s    = valid_b && !empty_s;
    bypass_s = valid_b && empty_s && valid_a;
    udf_s    = valid_b && empty_s && !valid_a;
    pair_s   = pop_s || bypass_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_s   = valid_a && !bypass_s && (!full_s || pop_s);
    ovf_s    = valid_a && full_s && !pop_s;
    if (pop_s) begin
      a_op_s = mem_r[rd_ptr_r];
    end else begin
      a_op_s = data_a;
    end
    diff_s = {1'b0, data_b} - {1'b0, a_op_s};
    if (x_r == X_LAST) begin
      x_nxt_s = {CNT_DW{1'b0}};
      if (y_r == Y_LAST) begin
        y_nxt_s = {CNT_DW{1'b0}};
        last_s  = 1'b1;
      end else begin
        y_nxt_s = y_r + CNT_DW'(1);
        last_s  = 1'b0;
      end
    end else begin
      x_nxt_s = x_r + CNT_DW'(1);
      y_nxt_s = y_r;
      last_s  = 1'b0;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_a;
    end
  end

  // Pointers, occupancy, coordinate counters, sticky errors and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      cnt_r     <= {(AW+1){1'b0}};
      x_r       <= {CNT_DW{1'b0}};
      y_r       <= {CNT_DW{1'b0}};
      valid_dog <= 1'b0;
      data_dog  <= {(DW+1){1'b0}};
      x_dog     <= {CNT_DW{1'b0}};
      y_dog     <= {CNT_DW{1'b0}};
      frame_end <= 1'b0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (ovf_s) begin
        err_ovf <= 1'b1;
      end
      if (udf_s) begin
        err_udf <= 1'b1;
      end
      valid_dog <= pair_s;
      if (pair_s) begin
        data_dog  <= diff_s;
        x_dog     <= x_r;
        y_dog     <= y_r;
        frame_end <= last_s;
        x_r       <= x_nxt_s;
        y_r       <= y_nxt_s;
      end else begin
        data_dog  <= {(DW+1){1'b0}};
        x_dog     <= {CNT_DW{1'b0}};
        y_dog     <= {CNT_DW{1'b0}};
        frame_end <= 1'b0;
      end
    end
  end

  assign fifo_cnt = cnt_r;

endmodule

// File: doc/dog_sub.md
# dog_sub

Difference-of-Gaussian stage directly downstream of the 2D Gaussian filter. It takes two Gaussian-filtered pixel streams of the same frame: stream A from the smaller-sigma filter and stream B from the larger-sigma filter. Stream A leads B by a fixed but parameter-dependent latency, so A is held in an alignment FIFO. The block pairs pixels in raster order and emits the signed difference B − A with pixel coordinates, ready for the 3×3×3 extrema detector.

## Interface
Parameters:
- WIDE, 230, frame width in pixels
- HIGN, 235, frame height in pixels
- DW, 16, pixel width of inputs (unsigned)
- CNT_DW, 16, coordinate counter width
- AW, 10, FIFO address width; depth = 2^AW entries

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- valid_a  input  1  stream A pixel strobe
- data_a  input  DW  stream A pixel (small sigma)
- valid_b  input  1  stream B pixel strobe
- data_b  input  DW  stream B pixel (large sigma)
- valid_dog  output  1  output pixel strobe
- data_dog  output  DW+1  signed two's-complement difference B − A
- x_dog  output  CNT_DW  column of output pixel
- y_dog  output  CNT_DW  row of output pixel
- frame_end  output  1  high with the last pixel of a frame (x=WIDE-1, y=HIGN-1)
- fifo_cnt  output  AW+1  current FIFO occupancy
- err_ovf  output  1  sticky: push while FIFO full
- err_udf  output  1  sticky: B pixel with no A pixel available

## Operation
- Reset value of every output is 0. Reset clears the FIFO pointers, occupancy, the coordinate counters and both error flags. Reset mid-frame discards all buffered data, and pairing restarts with the next A pixel.
- FIFO: synchronous, first-word-fall-through head register, depth 2^AW, holds data_a only.
- Push: valid_a=1 and the FIFO is not full. If the FIFO is full, the A pixel is dropped and err_ovf is set. Exception: a pop in the same cycle frees a slot, so the push succeeds.
- Pairing on valid_b=1:
  - FIFO non-empty: A operand = FIFO head; pop. A simultaneous valid_a pushes normally, and occupancy is unchanged.
  - FIFO empty and valid_a=1 same cycle: bypass. A operand = data_a, and nothing is written to the FIFO.
  - FIFO empty and valid_a=0: underflow. No output is produced, err_udf is set, and the coordinate counters do not advance.
- Arithmetic: data_dog = {1'b0,data_b} − {1'b0,data_a}, computed in DW+1 bits, signed. No saturation is needed: the range is −(2^DW−1) to +(2^DW−1).
- Coordinates: x_dog and y_dog carry the position of the pixel being output.
  - Internal counters advance after each produced pixel.
  - x wraps from WIDE-1 to 0 and increments y.
  - At x=WIDE-1 and y=HIGN-1, both wrap to 0 and frame_end is asserted with that pixel.
- Error flags stay set until rst.
- fifo_cnt reflects occupancy after the previous edge's push/pop: +1 on push only, −1 on pop only, unchanged on both or neither.

## Timing
- Latency: valid_b sampled at edge N gives valid_dog, data_dog, x_dog, y_dog and frame_end registered at edge N+1 (1 cycle).
- valid_dog is a single-cycle strobe per paired pixel. Outside valid cycles, data_dog, x_dog, y_dog and frame_end are driven to 0.
- Throughput: one pixel per cycle sustained on both streams. There is no backpressure and no ready signal; the upstream streams are free-running.
- A steady-state lead of A over B of up to 2^AW pixels is absorbed without loss. Gaps in either stream (valid low) are tolerated.
- Full-boundary push+pop in the same cycle must succeed with no err_ovf. Empty-boundary bypass must not change fifo_cnt.

## Test plan
- Lead alignment: WIDE=8, HIGN=4. A ramps 0..31, starting 5 cycles before B; B = 2×(A index) with the same pixel order. Required: 32 outputs with data_dog = +index, coordinates in raster order, frame_end only on output 31, err flags 0, fifo_cnt holds at 5 in steady state.
- Negative result: A=0xFFFF, B=0x0000 → data_dog = 17'h10001 (−65535). A=0, B=0xFFFF → 17'h0FFFF.
- Bypass: FIFO empty, valid_a and valid_b asserted in the same cycle with A=10, B=3. Required: data_dog = −7 one cycle later, fifo_cnt stays 0.
- Overflow: AW=2. Push 4 A pixels with no B, then a 5th A. Required: fifo_cnt=4, err_ovf=1. The 5th pixel is lost, and the next 4 B pixels pair with A pixels 1–4.
- Underflow: valid_b with empty FIFO and valid_a=0. Required: no valid_dog, err_udf=1, coordinates unchanged. A following normal pair outputs at (0,0).
- Reset mid-frame: assert rst with fifo_cnt=3 at x=5. Required: all outputs 0 the next cycle, fifo_cnt=0, and the next pair is output at (0,0).
